fpu_addsub_arbiter: RTL

- Shares one combinational fpu_add_sub instance among NUM_REQ requesters using round-robin arbitration.
- Each requester has a valid/ready request channel carrying a, b and op.
- The block latches the granted operands, drives the shared unit, and registers its result and 7 status flags.
- Results return on a single response channel tagged with the requester index. It sits between client pipelines and the FP add/sub datapath.

---
 rtl/fpu_addsub_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fpu_addsub_arbiter.sv
// fpu_addsub_arbiter
//   Round-robin front end that time-shares one combinational FP add/sub unit
//   among NUM_REQ requesters. One operation is in flight at a time:
//   IDLE (grant/accept) -> EXEC (unit settles) -> RESP (hold until taken).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester handshake (req_ready one-hot or 0)
//   req_a/req_b              32-bit operands, requester i at [32i+31:32i]
//   req_op                   per-requester op, 0 = add, 1 = subtract
//   fpu_a/fpu_b/fpu_op       operands to the shared unit (registered)
//   fpu_result/fpu_flags     combinational result and status from the unit
//   rsp_valid/rsp_ready      response handshake
//   rsp_id                   index of the requester owning the response
//   rsp_result/rsp_flags     registered result and status
//   busy                     high whenever the FSM is not IDLE
module fpu_addsub_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [32*NUM_REQ-1:0] req_a,
   input  logic [32*NUM_REQ-1:0] req_b,
   input  logic [NUM_REQ-1:0]    req_op,
   output logic [31:0]           fpu_a,
   output logic [31:0]           fpu_b,
   output logic                  fpu_op,
   input  logic [31:0]           fpu_result,
   input  logic [6:0]            fpu_flags,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [31:0]           rsp_result,
   output logic [6:0]            rsp_flags,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [ID_W-1:0]             r_rr_ptr;
   logic [31:0]                 r_op_a;
   logic [31:0]                 r_op_b;
   logic                        r_op_op;
   logic [ID_W-1:0]             r_id;
   logic                        r_rsp_valid;
   logic [ID_W-1:0]             r_rsp_id;
   logic [31:0]                 r_rsp_result;
   logic [6:0]                  r_rsp_flags;

   logic [NUM_REQ-1:0][31:0]    w_a_arr;
   logic [NUM_REQ-1:0][31:0]    w_b_arr;
   logic [ID_W-1:0]             w_gnt;
   logic                        w_any;
   int                          w_best;
   logic [NUM_REQ-1:0]          w_ready;
   logic                        w_accept;

   assign w_a_arr = req_a;
   assign w_b_arr = req_b;

   // Search distance of requester i from the slot just after the pointer;
   // the smallest distance among valid requesters wins.
   function automatic int f_dist(input int i, input int p);
      return (i - p - 1 + 2 * NUM_REQ) % NUM_REQ;
   endfunction

   always_comb begin
      w_any  = 1'b0;
      w_gnt  = '0;
      w_best = NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i] && (f_dist(i, int'(r_rr_ptr)) < w_best)) begin
            w_best = f_dist(i, int'(r_rr_ptr));
            w_gnt  = ID_W'(i);
            w_any  = 1'b1;
         end
      end
   end

   // Ready is only offered in IDLE and is masked by reset so nothing can be
   // accepted on the reset edge.
   always_comb begin
      w_ready = '0;
      if (!rst && (r_state == IDLE) && w_any)
         w_ready[w_gnt] = 1'b1;
   end

   assign req_ready = w_ready;
   assign w_accept  = |(w_ready & req_valid);

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = EXEC;
         EXEC:    w_state_nxt = RESP;
         RESP:    if (rsp_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr     <= PTR_RST;
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_op_op      <= 1'b0;
         r_id         <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= '0;
         r_rsp_result <= '0;
         r_rsp_flags  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_op_a   <= w_a_arr[w_gnt];
                  r_op_b   <= w_b_arr[w_gnt];
                  r_op_op  <= req_op[w_gnt];
                  r_id     <= w_gnt;
                  r_rr_ptr <= w_gnt;
               end
            end
            EXEC: begin
               r_rsp_result <= fpu_result;
               r_rsp_flags  <= fpu_flags;
               r_rsp_id     <= r_id;
               r_rsp_valid  <= 1'b1;
            end
            RESP: begin
               if (rsp_ready) r_rsp_valid <= 1'b0;
            end
            default: r_rsp_valid <= 1'b0;
         endcase
      end
   end

   // The shared unit only ever sees latched operands, so it holds its inputs
   // between operations.
   assign fpu_a      = r_op_a;
   assign fpu_b      = r_op_b;
   assign fpu_op     = r_op_op;

   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_result = r_rsp_result;
   assign rsp_flags  = r_rsp_flags;
   assign busy       = (r_state != IDLE);

endmodule
